systolic_controller: RTL

- Sequencer for the buffered systolic array module.
- Accepts a start command plus a beat count, then streams operand row pairs into the top/left double buffers and swaps them.
- Pulses shift/accumulate once per beat, drains the array, then streams all MATRIX_SIZE² accumulator values out through a valid/ready port.
- Sits between the host/DMA stream logic and the array module; it is the only driver of that module's control inputs.

---
 rtl/systolic_controller.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/systolic_controller.sv
// Sequencer for the buffered systolic array: loads operand rows, steps, drains and streams results.
// Optional performance counters are built when SYSTOLIC_CTRL_PERF_EN is defined.
module systolic_controller #(
  parameter int DATA_WIDTH     = 8,
  parameter int MATRIX_SIZE    = 8,
  parameter int ADDR_WIDTH     = $clog2(MATRIX_SIZE),
  parameter int ACC_WIDTH      = 32,
  parameter int ACC_ADDR_WIDTH = $clog2(MATRIX_SIZE*MATRIX_SIZE),
  parameter int BEAT_WIDTH     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [BEAT_WIDTH-1:0]     num_beats,
  output logic                      busy,
  output logic                      done,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_top,
  input  logic [DATA_WIDTH-1:0]     in_left,
  output logic                      acc_rst,
  output logic                      acc_en,
  output logic                      shift_en,
  output logic [ACC_ADDR_WIDTH-1:0] addr_acc,
  input  logic [ACC_WIDTH-1:0]      acc_in,
  output logic                      buffer_rst_top,
  output logic                      buffer_rst_left,
  output logic                      load_en_top,
  output logic                      load_en_left,
  output logic                      swap_buffers_top,
  output logic                      swap_buffers_left,
  output logic [ADDR_WIDTH-1:0]     addr_top,
  output logic [ADDR_WIDTH-1:0]     addr_left,
  output logic [DATA_WIDTH-1:0]     data_in_top,
  output logic [DATA_WIDTH-1:0]     data_in_left,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_WIDTH-1:0]      out_data,
  output logic [ACC_ADDR_WIDTH-1:0] out_index
`ifdef SYSTOLIC_CTRL_PERF_EN
  ,
  output logic [31:0]               perf_cycles,
  output logic [31:0]               perf_stall
`endif
);

  localparam int DRAIN_W = $clog2(2*MATRIX_SIZE);
  localparam logic [DRAIN_W-1:0]        DRAIN_LAST = DRAIN_W'(2*MATRIX_SIZE-3);
  localparam logic [ADDR_WIDTH-1:0]     ELEM_LAST  = ADDR_WIDTH'(MATRIX_SIZE-1);
  localparam logic [ACC_ADDR_WIDTH-1:0] RD_LAST    = ACC_ADDR_WIDTH'(MATRIX_SIZE*MATRIX_SIZE-1);

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_SWAP, S_STEP,
    S_FLUSH1, S_FLUSH2, S_DRAIN, S_READ, S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [BEAT_WIDTH-1:0]     num_beats_q, num_beats_d;
  logic [BEAT_WIDTH-1:0]     beat_cnt_q, beat_cnt_d, beat_nxt;
  logic [ADDR_WIDTH-1:0]     elem_cnt_q, elem_cnt_d;
  logic [DRAIN_W-1:0]        drain_cnt_q, drain_cnt_d;
  logic [ACC_ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      in_ready_q, in_ready_d;
  logic                      out_valid_q, out_valid_d;
  logic                      acc_rst_q, acc_rst_d;
  logic                      buf_rst_q, buf_rst_d;
  logic                      swap_q, swap_d;
  logic                      step_q, step_d;
  logic                      load_en_q, load_en_d;
  logic [ADDR_WIDTH-1:0]     wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]     wr_top_q, wr_top_d;
  logic [DATA_WIDTH-1:0]     wr_left_q, wr_left_d;
  logic                      hs_in, hs_out;

  always_comb begin
    state_d     = state_q;
    num_beats_d = num_beats_q;
    beat_cnt_d  = beat_cnt_q;
    elem_cnt_d  = elem_cnt_q;
    drain_cnt_d = drain_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    hs_in       = in_ready_q & in_valid;
    hs_out      = out_valid_q & out_ready;
    beat_nxt    = beat_cnt_q + BEAT_WIDTH'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_beats_d = num_beats;
          state_d     = (num_beats == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        beat_cnt_d = '0;
        elem_cnt_d = '0;
        state_d    = S_LOAD;
      end
      S_LOAD: begin
        if (hs_in) begin
          if (elem_cnt_q == ELEM_LAST) begin
            elem_cnt_d = '0;
            state_d    = S_SWAP;
          end else begin
            elem_cnt_d = elem_cnt_q + ADDR_WIDTH'(1);
          end
        end
      end
      S_SWAP: state_d = S_STEP;
      S_STEP: begin
        beat_cnt_d = beat_nxt;
        state_d    = (beat_nxt < num_beats_q) ? S_LOAD : S_FLUSH1;
      end
      S_FLUSH1: state_d = S_FLUSH2;
      S_FLUSH2: begin
        drain_cnt_d = '0;
        state_d     = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          drain_cnt_d = '0;
          state_d     = S_READ;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
        end
      end
      S_READ: begin
        if (hs_out) begin
          if (rd_cnt_q == RD_LAST) begin
            rd_cnt_d = '0;
            state_d  = S_DONE;
          end else begin
            rd_cnt_d = rd_cnt_q + ACC_ADDR_WIDTH'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The last operand write lands in the SWAP cycle, so the swap and step strobes
    // trail their states by one cycle to keep writes, swaps and shifts ordered.
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    in_ready_d  = (state_d == S_LOAD);
    out_valid_d = (state_d == S_READ);
    acc_rst_d   = (state_d == S_CLEAR);
    buf_rst_d   = (state_d == S_CLEAR) || (state_d == S_FLUSH1);
    swap_d      = (state_q == S_SWAP)  || (state_d == S_FLUSH2);
    step_d      = (state_q == S_STEP)  || (state_d == S_DRAIN);
    load_en_d   = hs_in;
    wr_addr_d   = hs_in ? elem_cnt_q : '0;
    wr_top_d    = hs_in ? in_top     : '0;
    wr_left_d   = hs_in ? in_left    : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      num_beats_q <= '0;
      beat_cnt_q  <= '0;
      elem_cnt_q  <= '0;
      drain_cnt_q <= '0;
      rd_cnt_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      acc_rst_q   <= 1'b0;
      buf_rst_q   <= 1'b0;
      swap_q      <= 1'b0;
      step_q      <= 1'b0;
      load_en_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_top_q    <= '0;
      wr_left_q   <= '0;
    end else begin
      state_q     <= state_d;
      num_beats_q <= num_beats_d;
      beat_cnt_q  <= beat_cnt_d;
      elem_cnt_q  <= elem_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      acc_rst_q   <= acc_rst_d;
      buf_rst_q   <= buf_rst_d;
      swap_q      <= swap_d;
      step_q      <= step_d;
      load_en_q   <= load_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_top_q    <= wr_top_d;
      wr_left_q   <= wr_left_d;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign in_ready          = in_ready_q;
  assign acc_rst           = acc_rst_q;
  assign acc_en            = step_q;
  assign shift_en          = step_q;
  assign buffer_rst_top    = buf_rst_q;
  assign buffer_rst_left   = buf_rst_q;
  assign load_en_top       = load_en_q;
  assign load_en_left      = load_en_q;
  assign swap_buffers_top  = swap_q;
  assign swap_buffers_left = swap_q;
  assign addr_top          = wr_addr_q;
  assign addr_left         = wr_addr_q;
  assign data_in_top       = wr_top_q;
  assign data_in_left      = wr_left_q;
  assign out_valid         = out_valid_q;
  assign addr_acc          = rd_cnt_q;
  assign out_index         = rd_cnt_q;
  // Gated so the result port reads zero outside READ, including under reset.
  assign out_data          = out_valid_q ? acc_in : '0;

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_stall_d  = perf_stall_q;
    if (state_q == S_IDLE && start) begin
      perf_cycles_d = '0;
      perf_stall_d  = '0;
    end else begin
      if (state_q != S_IDLE && perf_cycles_q != '1)
        perf_cycles_d = perf_cycles_q + 32'd1;
      if (((state_q == S_LOAD && !in_valid) || (state_q == S_READ && !out_ready)) &&
          perf_stall_q != '1)
        perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule
